// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_pkg
// Purpose  : Shared types, widths and address-split helpers for the
//            direct-mapped instruction cache.
// Contents : state_t (LOOKUP/REFILL), width functions, addr_off/idx/tag.
// Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

  localparam int ADDR_W             = 30;
  localparam int DATA_W             = 32;
  localparam int DEF_LINES          = 16;
  localparam int DEF_WORDS_PER_LINE = 4;

  typedef enum logic [0:0] {
    LOOKUP = 1'b0,
    REFILL = 1'b1
  } state_t;

  function automatic int off_width(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int lines, input int words_per_line);
    return ADDR_W - idx_width(lines) - off_width(words_per_line);
  endfunction

  localparam int DEF_OFF_W = off_width(DEF_WORDS_PER_LINE);
  localparam int DEF_IDX_W = idx_width(DEF_LINES);
  localparam int DEF_TAG_W = tag_width(DEF_LINES, DEF_WORDS_PER_LINE);

  // Split helpers return full-width values; callers truncate to the field width.
  function automatic logic [ADDR_W-1:0] addr_off(input logic [ADDR_W-1:0] addr,
                                                 input int off_w);
    return addr & ((ADDR_W'(1) << off_w) - ADDR_W'(1));
  endfunction

  function automatic logic [ADDR_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr,
                                                 input int off_w, input int idx_w);
    return (addr >> off_w) & ((ADDR_W'(1) << idx_w) - ADDR_W'(1));
  endfunction

  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                 input int off_w, input int idx_w);
    return addr >> (off_w + idx_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_responder_if
// Purpose  : Bundles the fetch-side port and the refill memory port.
// Modports : slave  - the cache (consumes fetch/mem_ack, drives instr/mem_req)
//            master - the environment (fetch stage + backing memory)
// Revision : 1.0 - initial release
// ============================================================================
interface icache_responder_if;
  import icache_pkg::*;

  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_en;
  logic              flush;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;

  modport slave (
    input  fetch_addr, fetch_en, flush, mem_ack, mem_data,
    output instr_out, instr_valid, stall, mem_req, mem_addr
  );

  modport master (
    output fetch_addr, fetch_en, flush, mem_ack, mem_data,
    input  instr_out, instr_valid, stall, mem_req, mem_addr
  );

endinterface
`default_nettype wire

// File: rtl/icache_tag_array.sv
`default_nettype none
// ============================================================================
// Module   : icache_tag_array
// Purpose  : Per-line valid bits and tags. Combinational read, single-index
//            write, and a clear-all of the valid bits (clear-all wins).
// Ports    : clk, async_rst_n, rd_idx -> rd_valid/rd_tag,
//            wr_en/wr_idx/wr_tag (sets valid), clr_all
// Revision : 1.0 - initial release
// ============================================================================
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int TAG_W = DEF_TAG_W
) (
  input  wire logic                        clk,
  input  wire logic                        async_rst_n,
  input  wire logic [idx_width(LINES)-1:0] rd_idx,
  output      logic                        rd_valid,
  output      logic [TAG_W-1:0]            rd_tag,
  input  wire logic                        wr_en,
  input  wire logic [idx_width(LINES)-1:0] wr_idx,
  input  wire logic [TAG_W-1:0]            wr_tag,
  input  wire logic                        clr_all
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tags [LINES];

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_valid <= '0;
    end else if (clr_all) begin
      r_valid <= '0;
    end else if (wr_en) begin
      r_valid[wr_idx] <= 1'b1;
    end
  end

  // Tags need no reset: they are only consulted through a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_tags[wr_idx] <= wr_tag;
    end
  end

  assign rd_valid = r_valid[rd_idx];
  assign rd_tag   = r_tags[rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache_responder.sv
`default_nettype none
// ============================================================================
// Module   : icache_responder
// Purpose  : Direct-mapped, read-only instruction cache answering the fetch
//            stage one cycle after address capture. A miss raises stall and
//            refills the whole line, offset 0 first, over mem_req/mem_ack.
// Ports    : clk, async_rst_n (async, active low)
//            bus (slave): fetch_addr/fetch_en/flush -> instr_out/instr_valid/
//            stall; refill port mem_req/mem_addr/mem_ack/mem_data
// Revision : 1.0 - initial release
// ============================================================================
module icache_responder
  import icache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input wire logic          clk,
  input wire logic          async_rst_n,
  icache_responder_if.slave bus
);

  localparam int OFF_W = off_width(WORDS_PER_LINE);
  localparam int IDX_W = idx_width(LINES);
  localparam int TAG_W = tag_width(LINES, WORDS_PER_LINE);
  localparam logic [OFF_W-1:0] C_LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_req_live;
  logic [OFF_W-1:0]  r_beat;
  logic              r_flush_pend;
  logic [DATA_W-1:0] r_data [LINES][WORDS_PER_LINE];

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_line_valid;
  logic [TAG_W-1:0]  w_line_tag;
  logic              w_hit;
  logic              w_stall;
  logic              w_capture;
  logic              w_beat_ack;
  logic              w_last_ack;
  logic              w_flush_seen;
  logic              w_tag_wr;
  logic              w_clr_all;

  // Lookup always works on the registered address, so it lines up with the
  // fetch stage's registered PC.
  assign w_off = OFF_W'(addr_off(r_req_addr, OFF_W));
  assign w_idx = IDX_W'(addr_idx(r_req_addr, OFF_W, IDX_W));
  assign w_tag = TAG_W'(addr_tag(r_req_addr, OFF_W, IDX_W));

  assign w_hit   = (r_state == LOOKUP) && r_req_live && w_line_valid && (w_line_tag == w_tag);
  // Stall rises combinationally in the miss cycle so the core freezes at once.
  assign w_stall = (r_state == REFILL) || (r_req_live && !w_hit);

  assign w_capture  = bus.fetch_en && !w_stall;
  assign w_beat_ack = (r_state == REFILL) && bus.mem_ack;
  assign w_last_ack = w_beat_ack && (r_beat == C_LAST_BEAT);

  // A flush seen at any point of a refill (including its final beat) keeps
  // the new line invalid and wipes the whole array when the refill ends.
  assign w_flush_seen = r_flush_pend || bus.flush;
  assign w_tag_wr     = w_last_ack && !w_flush_seen;
  assign w_clr_all    = ((r_state == LOOKUP) && bus.flush) || (w_last_ack && w_flush_seen);

  icache_tag_array #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_tag_array (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .rd_idx      (w_idx),
    .rd_valid    (w_line_valid),
    .rd_tag      (w_line_tag),
    .wr_en       (w_tag_wr),
    .wr_idx      (w_idx),
    .wr_tag      (w_tag),
    .clr_all     (w_clr_all)
  );

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state      <= LOOKUP;
      r_req_addr   <= '0;
      r_req_live   <= 1'b0;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_capture) begin
        r_req_addr <= bus.fetch_addr;
        r_req_live <= 1'b1;
      end

      case (r_state)
        LOOKUP: begin
          r_flush_pend <= 1'b0;
          if (r_req_live && !w_hit) begin
            r_state <= REFILL;
            r_beat  <= '0;
          end
        end
        REFILL: begin
          if (w_last_ack) begin
            r_state      <= LOOKUP;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
          end else begin
            if (bus.flush) begin
              r_flush_pend <= 1'b1;
            end
            if (w_beat_ack) begin
              r_beat <= r_beat + OFF_W'(1);
            end
          end
        end
        default: begin
          r_state <= LOOKUP;
        end
      endcase
    end
  end

  // The refill always targets the line of the captured address, so the
  // write index is the lookup index.
  always_ff @(posedge clk) begin
    if (w_beat_ack) begin
      r_data[w_idx][r_beat] <= bus.mem_data;
    end
  end

  assign bus.instr_valid = w_hit;
  assign bus.instr_out   = w_hit ? r_data[w_idx][w_off] : '0;
  assign bus.stall       = w_stall;
  assign bus.mem_req     = (r_state == REFILL);
  assign bus.mem_addr    = (r_state == REFILL) ? {w_tag, w_idx, r_beat} : '0;

endmodule
`default_nettype wire

// File: tb/tb_icache_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_responder
// Purpose  : Self-checking bench for icache_responder. A line-level model
//            (valid/tag per line, constant backing memory) predicts hit or
//            miss per fetch; refill beats, waits and flushes are randomised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_responder;

  localparam int LINES = 16;
  localparam int WPL   = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  icache_responder_if bus ();

  icache_responder #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WPL)
  ) dut (
    .clk         (clk),
    .async_rst_n (rst_n),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Backing memory: fixed contents, with the directed words at 0x0 and 0x40.
  function automatic logic [31:0] mem_word(input int unsigned a);
    if (a < 4) return 32'hA0 + a;
    if (a >= 32'h40 && a < 32'h44) return 32'hB0 + (a - 32'h40);
    return a * 32'h9E3779B1 + 32'h1234_5678;
  endfunction

  function automatic bit model_hit(input int unsigned a);
    int unsigned idx = (a / WPL) % LINES;
    return m_valid[idx] && (m_tag[idx] == a / (WPL * LINES));
  endfunction

  function automatic void model_fill(input int unsigned a);
    int unsigned idx = (a / WPL) % LINES;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = a / (WPL * LINES);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve one beat: wait w cycles with req held, then ack with the memory word.
  task automatic serve_beat(input int unsigned addr, input int w, input bit fl);
    check("refill_req", 32'(bus.mem_req), 32'd1);
    check("refill_addr", 32'(bus.mem_addr), 32'(addr));
    check("refill_stall", 32'(bus.stall), 32'd1);
    check("refill_ivalid", 32'(bus.instr_valid), 32'd0);
    for (int k = 0; k < w; k++) begin
      bus.mem_data = $urandom;
      step();
      check("wait_req", 32'(bus.mem_req), 32'd1);
      check("wait_addr", 32'(bus.mem_addr), 32'(addr));
    end
    bus.mem_ack  = 1'b1;
    bus.mem_data = mem_word(addr);
    bus.flush    = fl;
    step();
    bus.mem_ack  = 1'b0;
    bus.mem_data = $urandom;
    bus.flush    = 1'b0;
  endtask

  // One fetch: capture a, follow any refill(s), end on the cycle it hits.
  // wait_cyc < 0 selects random inter-beat waits; flush_beat < 0 means none.
  task automatic do_fetch(input int unsigned a, input bit flush_first,
                          input int flush_beat, input int wait_cyc);
    int unsigned base = a - (a % WPL);
    int fb = flush_beat;
    bus.fetch_addr = 30'(a);
    bus.fetch_en   = 1'b1;
    bus.flush      = flush_first;
    if (flush_first) begin
      #1;
      check("flush_cycle_hit", 32'(bus.instr_valid), 32'd1);
      model_clear();
    end
    step();
    bus.flush = 1'b0;
    while (!model_hit(a)) begin
      check("miss_stall", 32'(bus.stall), 32'd1);
      check("miss_ivalid", 32'(bus.instr_valid), 32'd0);
      step();
      for (int b = 0; b < WPL; b++) begin
        serve_beat(base + b, (wait_cyc < 0) ? int'($urandom_range(0, 3)) : wait_cyc, b == fb);
      end
      if (fb >= 0) model_clear();
      else model_fill(a);
      fb = -1;
    end
    check("hit_ivalid", 32'(bus.instr_valid), 32'd1);
    check("hit_instr", bus.instr_out, mem_word(a));
    check("hit_stall", 32'(bus.stall), 32'd0);
    check("hit_req", 32'(bus.mem_req), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.fetch_addr = '0;
    bus.fetch_en   = 1'b0;
    bus.flush      = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.mem_data   = '0;
    model_clear();
    repeat (3) step();
    check("rst_ivalid", 32'(bus.instr_valid), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_maddr", 32'(bus.mem_addr), 32'd0);
    check("rst_instr", bus.instr_out, 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_stall", 32'(bus.stall), 32'd0);
    check("idle_ivalid", 32'(bus.instr_valid), 32'd0);

    // Cold miss with two wait cycles per beat, then sequential hits.
    do_fetch(32'h0, 1'b0, -1, 2);
    do_fetch(32'h1, 1'b0, -1, 0);
    do_fetch(32'h2, 1'b0, -1, 0);
    do_fetch(32'h3, 1'b0, -1, 0);
    // Conflict on index 0, then the original line misses again.
    do_fetch(32'h40, 1'b0, -1, 1);
    do_fetch(32'h0, 1'b0, -1, 0);
    // Flush in LOOKUP together with the next capture.
    do_fetch(32'h1, 1'b1, -1, 0);
    // Flush on beat 2 of a refill forces a second refill.
    do_fetch(32'h40, 1'b0, 2, 1);
    do_fetch(32'h0, 1'b0, -1, 0);

    // Reset in the middle of a refill (after beat 1).
    bus.fetch_addr = 30'h100;
    bus.fetch_en   = 1'b1;
    step();
    check("rr_miss_stall", 32'(bus.stall), 32'd1);
    step();
    for (int b = 0; b < 2; b++) begin
      bus.mem_ack  = 1'b1;
      bus.mem_data = mem_word(32'h100 + b);
      step();
      bus.mem_ack  = 1'b0;
    end
    check("rr_beat2_addr", 32'(bus.mem_addr), 32'h102);
    rst_n = 1'b0;
    #1;
    check("rr_req", 32'(bus.mem_req), 32'd0);
    check("rr_stall", 32'(bus.stall), 32'd0);
    check("rr_ivalid", 32'(bus.instr_valid), 32'd0);
    check("rr_maddr", 32'(bus.mem_addr), 32'd0);
    bus.fetch_en = 1'b0;
    model_clear();
    step();
    step();
    rst_n = 1'b1;
    step();
    do_fetch(32'h0, 1'b0, -1, 0);

    // Random traffic over four tags so lines conflict and re-hit.
    for (int i = 0; i < 60; i++) begin
      int unsigned a  = $urandom_range(0, 3) * 64 + $urandom_range(0, 63);
      bit          ff = ($urandom_range(0, 7) == 0);
      int          fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_fetch(a, ff, fb, -1);
    end

    bus.fetch_en = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
